// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: controller states,
// Booth operation codes and the recoding of the two multiplier bits.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      NOP,
      ADD,
      SUB
   } op_t;

   // Radix-2 recoding: a 0->1 transition going right adds M, 1->0 subtracts M.
   function automatic op_t booth_decode(input logic q0, input logic q_m1);
      case ({q0, q_m1})
         2'b01:   return ADD;
         2'b10:   return SUB;
         default: return NOP;
      endcase
   endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into the accumulator,
// then an arithmetic right shift of the {acc, q, q_m1} chain.
module booth_step
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic signed [WIDTH:0]   acc,
   input  logic        [WIDTH-1:0] q,
   input  logic                    q_m1,
   input  logic signed [WIDTH:0]   m,
   output logic signed [WIDTH:0]   acc_next,
   output logic        [WIDTH-1:0] q_next,
   output logic                    q_m1_next
);

   op_t                  op;
   logic signed [WIDTH:0] sum;

   // The extra accumulator bit keeps acc - m exact even for the most-negative M.
   always_comb begin
      op  = booth_decode(q[0], q_m1);
      sum = acc;
      case (op)
         ADD:     sum = acc + m;
         SUB:     sum = acc - m;
         default: sum = acc;
      endcase
      acc_next  = {sum[WIDTH], sum[WIDTH:1]};
      q_next    = {sum[0], q[WIDTH-1:1]};
      q_m1_next = q[0];
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth signed multiplier: accepts an operand pair in IDLE,
// runs WIDTH add/sub-and-shift steps, then holds the 2*WIDTH-bit product in DONE.
module booth_mul_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       din_multiplicand,
   input  logic [WIDTH-1:0]       din_multiplier,
   input  logic                   din_valid,
   output logic                   din_ready,
   output logic [2*WIDTH-1:0]     dout_product,
   output logic                   dout_valid,
   input  logic                   dout_ready
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   state_t                state;
   state_t                state_nxt;
   logic signed [WIDTH:0] acc;
   logic signed [WIDTH:0] m;
   logic [WIDTH-1:0]      q;
   logic                  q_m1;
   logic [CW-1:0]         cnt;

   logic signed [WIDTH:0] acc_step;
   logic [WIDTH-1:0]      q_step;
   logic                  q_m1_step;

   booth_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .acc       (acc),
      .q         (q),
      .q_m1      (q_m1),
      .m         (m),
      .acc_next  (acc_step),
      .q_next    (q_step),
      .q_m1_next (q_m1_step)
   );

   // Handshake outputs depend on state only, so no input-to-output paths exist.
   always_comb begin
      state_nxt  = state;
      din_ready  = 1'b0;
      dout_valid = 1'b0;
      case (state)
         IDLE: begin
            din_ready = 1'b1;
            if (din_valid) state_nxt = RUN;
         end
         RUN: begin
            if (cnt == LAST_STEP) state_nxt = DONE;
         end
         DONE: begin
            dout_valid = 1'b1;
            if (dout_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         m     <= '0;
         q     <= '0;
         q_m1  <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && din_valid) begin
            m    <= {din_multiplicand[WIDTH-1], din_multiplicand};
            q    <= din_multiplier;
            acc  <= '0;
            q_m1 <= 1'b0;
            cnt  <= '0;
         end else if (state == RUN) begin
            acc  <= acc_step;
            q    <= q_step;
            q_m1 <= q_m1_step;
            cnt  <= cnt + CW'(1);
         end
      end
   end

   // The low WIDTH accumulator bits and q form the product; registers only move in RUN.
   assign dout_product = {acc[WIDTH-1:0], q};

endmodule
